pipe_stage_ctrl: RTL and testbench
==================================

// Module: pipe_stage_ctrl
// PURPOSE
//  Parametrised stage controller for the in-order pipeline. It generalises the fixed StallF/StallD/FlushD/FlushE
//  hazard handling to STAGES stages.
//  Tracks a valid bit per pipe register and turns per-stage stall requests, multi-cycle memory busy and
//  control-flow redirects into per-stage load-enable and bubble (flush) strobes.
//  Also provides retirement and stall/flush performance counters for the testbench trace.
// PARAMETERS
//  STAGES     5   number of stages, index 0=fetch .. STAGES-1=writeback; legal range >=3
//  REDIR_STG  2   stage that resolves branches/jumps (execute); legal range 1..STAGES-2
//  MEM_STG    3   stage stalled by mem_busy_i; legal range REDIR_STG..STAGES-2
//  CNT_W      32  width of the performance counters
// PORTS
//  clk            in   1       clock, rising edge
//  rstn_i         in   1       asynchronous active-low reset
//  fetch_valid_i  in   1       instruction word valid in fetch (stage 0)
//  stall_req_i    in   STAGES  per-stage hold request (e.g. load-use in decode = bit 1)
//  mem_busy_i     in   1       memory access in MEM_STG not finished
//  redirect_i     in   1       taken branch/jump from REDIR_STG (PCSrcE)
//  cnt_clr_i      in   1       synchronous clear of all counters
//  stage_valid_o  out  STAGES  bit0=fetch_valid_i, bit s>0 = valid_q[s]
//  stage_en_o     out  STAGES  load enable of register feeding stage s (bit0 = PC enable)
//  stage_flush_o  out  STAGES  register feeding stage s loads a bubble; bit0 always 0
//  retire_o       out  1       instruction retires this cycle (= valid_q[STAGES-1])
//  retire_cnt_o   out  CNT_W   retired instructions
//  stall_cnt_o    out  CNT_W   cycles with fetch stalled (stall[0]=1, no redirect taken)
//  flush_cnt_o    out  CNT_W   redirects taken
// BEHAVIOUR
//  - Reset (rstn_i=0, async): valid_q[STAGES-1:1]=0 and all counters=0, both immediately.
//    Comb outputs follow their inputs, so with no requests after reset: en=all 1, flush=0.
//  - Stall chain, computed combinationally from top down:
//    stall[STAGES-1]=0 (writeback never stalls);
//    stall[s] = req[s] | stall[s+1] for s<STAGES-1, where req = stall_req_i, plus mem_busy_i at MEM_STG.
//  - redir_take = redirect_i & valid_q[REDIR_STG] & ~stall[REDIR_STG].
//    A redirect arriving while REDIR_STG is stalled is ignored; the source holds redirect_i until it is taken.
//  - en[s] = ~stall[s] | (redir_take & s<=REDIR_STG). A redirect overrides younger stall requests.
//  - flush[s] (s>=1) = (redir_take & s<=REDIR_STG) | (stall[s-1] & ~stall[s]).
//    The second term is bubble insertion below a held stage.
//  - Valid update at posedge, priority: flush[s] -> 0; else en[s] -> stage_valid_o[s-1]; else hold.
//  - Latency: an instruction accepted in fetch at cycle t retires at t+STAGES-1 when there are no stalls.
//  - At most one retire per cycle. Counters increment by 1 per event and wrap from 2^CNT_W-1 to 0.
//  - cnt_clr_i wins over a same-cycle increment: the counter reads 0 next cycle.
//  - Outputs are comb from the valid registers and inputs; no extra cycle of latency.
//  - Parameter violations are caught by an elaboration-time check (invalid config is a fatal error).
// TESTING (defaults STAGES=5, REDIR_STG=2, MEM_STG=3)
//  1 reset release, fetch_valid_i=1, no stalls -> stage_valid_o fills 00001,00011,..,11111;
//    first retire_o 4 cycles after fetch; retire_cnt_o=10 after 14 cycles
//  2 stall_req_i[1]=1 for 1 cycle -> stage_en_o=11100, stage_flush_o=00100;
//    next cycle valid_q[2]=0; stall_cnt_o=1
//  3 mem_busy_i=1 for 3 cycles -> stage_en_o=10000, stage_flush_o=10000;
//    valid_q[4]=0 for 3 cycles; 3-cycle gap in retire_o
//  4 redirect_i with valid_q[2]=1, same-cycle stall_req_i[1]=1 -> en=11111, flush=00110;
//    next cycle valid_q[2:1]=00; flush_cnt_o +1
//  5 redirect_i held during mem_busy_i=1 -> no flush and flush_cnt_o unchanged;
//    taken on the first cycle mem_busy_i=0
//  6 CNT_W=4: retire 17 instr -> retire_cnt_o wraps 15->0->1;
//    rstn_i pulse mid-stream -> valid_q and counters 0 immediately, with no clk edge needed

Source files
------------

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: per-stage valid tracking, stall/bubble/redirect
// strobes and perf counters for the in-order pipeline.
module pipe_stage_ctrl #(
  parameter int STAGES    = 5,
  parameter int REDIR_STG = 2,
  parameter int MEM_STG   = 3,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic              fetch_valid_i,
  input  logic [STAGES-1:0] stall_req_i,
  input  logic              mem_busy_i,
  input  logic              redirect_i,
  input  logic              cnt_clr_i,
  output logic [STAGES-1:0] stage_valid_o,
  output logic [STAGES-1:0] stage_en_o,
  output logic [STAGES-1:0] stage_flush_o,
  output logic              retire_o,
  output logic [CNT_W-1:0]  retire_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  if (STAGES < 3 || REDIR_STG < 1 || REDIR_STG > STAGES-2 ||
      MEM_STG < REDIR_STG || MEM_STG > STAGES-2) begin : g_bad_cfg
    $fatal(1, "pipe_stage_ctrl: illegal parameter set");
  end

  logic [STAGES-1:1] valid_q;
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] flush;
  logic [STAGES-2:0] req;
  logic              redir_take;
  logic              unused_req;

  // writeback never stalls, so its request bit has no effect
  assign unused_req = stall_req_i[STAGES-1];

  always_comb begin
    req = stall_req_i[STAGES-2:0];
    req[MEM_STG] = req[MEM_STG] | mem_busy_i;
  end

  always_comb begin
    stall = '0;
    for (int s = STAGES-2; s >= 0; s--) begin
      stall[s] = req[s] | stall[s+1];
    end
  end

  assign valid = {valid_q, fetch_valid_i};

  assign redir_take = redirect_i & valid[REDIR_STG]
                    & ~stall[REDIR_STG];

  // a taken redirect overrides younger stalls and
  // squashes everything up to the resolving stage
  always_comb begin
    en    = '0;
    flush = '0;
    for (int s = 0; s < STAGES; s++) begin
      en[s] = ~stall[s] | (redir_take & (s <= REDIR_STG));
    end
    for (int s = 1; s < STAGES; s++) begin
      flush[s] = (redir_take & (s <= REDIR_STG))
               | (stall[s-1] & ~stall[s]);
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
    end else begin
      for (int s = 1; s < STAGES; s++) begin
        if (flush[s]) begin
          valid_q[s] <= 1'b0;
        end else if (en[s]) begin
          valid_q[s] <= valid[s-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      retire_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      retire_cnt_o <= '0;
    end else if (valid_q[STAGES-1]) begin
      retire_cnt_o <= retire_cnt_o + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_o <= '0;
    end else if (stall[0] & ~redir_take) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      flush_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      flush_cnt_o <= '0;
    end else if (redir_take) begin
      flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

  assign stage_valid_o = valid;
  assign stage_en_o    = en;
  assign stage_flush_o = flush;
  assign retire_o      = valid_q[STAGES-1];

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb_pipe_stage_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the stage controller.
module tb_pipe_stage_ctrl;
  localparam int S = 5;
  localparam int R = 2;
  localparam int M = 3;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn_i;
  logic         fetch_valid_i;
  logic [S-1:0] stall_req_i;
  logic         mem_busy_i;
  logic         redirect_i;
  logic         cnt_clr_i;
  logic [S-1:0] stage_valid_o;
  logic [S-1:0] stage_en_o;
  logic [S-1:0] stage_flush_o;
  logic         retire_o;
  logic [W-1:0] retire_cnt_o;
  logic [W-1:0] stall_cnt_o;
  logic [W-1:0] flush_cnt_o;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(
    .STAGES(S), .REDIR_STG(R), .MEM_STG(M), .CNT_W(W)
  ) dut (
    .clk(clk),
    .rstn_i(rstn_i),
    .fetch_valid_i(fetch_valid_i),
    .stall_req_i(stall_req_i),
    .mem_busy_i(mem_busy_i),
    .redirect_i(redirect_i),
    .cnt_clr_i(cnt_clr_i),
    .stage_valid_o(stage_valid_o),
    .stage_en_o(stage_en_o),
    .stage_flush_o(stage_flush_o),
    .retire_o(retire_o),
    .retire_cnt_o(retire_cnt_o),
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
  );

  int nvec = 0;
  int nerr = 0;

  // model state: occupancy of pipe registers 1..S-1, counters mod 16
  bit mv[S];
  bit n_mv[S];
  int rc, sc, fc;
  int n_rc, n_sc, n_fc;
  logic [S-1:0] ex_valid, ex_en, ex_flush;
  logic         ex_retire;
  bit           ex_take;

  function automatic void model_reset();
    for (int s = 0; s < S; s++) mv[s] = 1'b0;
    rc = 0; sc = 0; fc = 0;
  endfunction

  // everything at or below the oldest requesting stage is held
  function automatic void model_eval();
    int top;
    logic [S-1:0] rq;
    top = -1;
    rq = stall_req_i;
    if (mem_busy_i) rq[M] = 1'b1;
    for (int s = 0; s < S-1; s++) if (rq[s]) top = s;
    ex_take = redirect_i && mv[R] && (R > top);
    ex_valid[0] = fetch_valid_i;
    for (int s = 1; s < S; s++) ex_valid[s] = mv[s];
    for (int s = 0; s < S; s++)
      ex_en[s] = (s > top) || (ex_take && s <= R);
    ex_flush[0] = 1'b0;
    for (int s = 1; s < S; s++)
      ex_flush[s] = (ex_take && s <= R) || (s-1 == top);
    ex_retire = mv[S-1];
    n_mv[0] = 1'b0;
    for (int s = 1; s < S; s++)
      n_mv[s] = ex_flush[s] ? 1'b0 :
                ex_en[s] ? ex_valid[s-1] : mv[s];
    n_rc = cnt_clr_i ? 0 : (rc + int'(ex_retire)) % 16;
    n_sc = cnt_clr_i ? 0 : (sc + int'(top >= 0 && !ex_take)) % 16;
    n_fc = cnt_clr_i ? 0 : (fc + int'(ex_take)) % 16;
  endfunction

  task automatic drive(input logic fv, input logic [S-1:0] rq,
                       input logic mb, input logic rd,
                       input logic clr);
    fetch_valid_i = fv;
    stall_req_i   = rq;
    mem_busy_i    = mb;
    redirect_i    = rd;
    cnt_clr_i     = clr;
    #2;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    mv = n_mv;
    rc = n_rc; sc = n_sc; fc = n_fc;
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < S; i++) begin
      drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    fetch_valid_i = 1'b0; stall_req_i = '0; mem_busy_i = 1'b0;
    redirect_i = 1'b0; cnt_clr_i = 1'b0;
    model_reset();
    #3;
    nvec++;
    if (stage_valid_o !== 5'b00000) begin
      nerr++; $display("FAIL reset_valid got %b want 00000", stage_valid_o);
    end
    nvec++;
    if (stage_en_o !== 5'b11111) begin
      nerr++; $display("FAIL reset_en got %b want 11111", stage_en_o);
    end
    nvec++;
    if (stage_flush_o !== 5'b00000) begin
      nerr++; $display("FAIL reset_flush got %b want 00000", stage_flush_o);
    end
    nvec++;
    if ({retire_cnt_o, stall_cnt_o, flush_cnt_o} !== 12'h000) begin
      nerr++;
      $display("FAIL reset_cnt got %h/%h/%h want 0/0/0",
               retire_cnt_o, stall_cnt_o, flush_cnt_o);
    end
    @(posedge clk);
    #1;
    rstn_i = 1'b1;
  endtask

  task automatic test_fill();
    logic [S-1:0] exp;
    int first;
    first = -1;
    for (int c = 0; c < 14; c++) begin
      drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
      exp = (c >= 4) ? 5'b11111 : 5'((1 << (c+1)) - 1);
      nvec++;
      if (stage_valid_o !== exp) begin
        nerr++;
        $display("FAIL fill_valid c=%0d got %b want %b", c, stage_valid_o, exp);
      end
      if (retire_o === 1'b1 && first < 0) first = c;
      tick();
    end
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (first != 4) begin
      nerr++; $display("FAIL fill_latency got %0d want 4", first);
    end
    nvec++;
    if (retire_cnt_o !== 4'd10) begin
      nerr++; $display("FAIL fill_retire_cnt got %0d want 10", retire_cnt_o);
    end
  endtask

  task automatic test_stall_decode();
    int sc0;
    fill();
    drive(1'b1, 5'b00010, 1'b0, 1'b0, 1'b0);
    sc0 = sc;
    nvec++;
    if (stage_en_o !== 5'b11100) begin
      nerr++; $display("FAIL stall_en got %b want 11100", stage_en_o);
    end
    nvec++;
    if (stage_flush_o !== 5'b00100) begin
      nerr++; $display("FAIL stall_flush got %b want 00100", stage_flush_o);
    end
    tick();
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (stage_valid_o[2] !== 1'b0) begin
      nerr++; $display("FAIL stall_bubble got %b want 0", stage_valid_o[2]);
    end
    nvec++;
    if (stall_cnt_o !== W'(sc0 + 1)) begin
      nerr++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt_o, (sc0+1)%16);
    end
    tick();
  endtask

  task automatic test_mem_busy();
    fill();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, '0, 1'b1, 1'b0, 1'b0);
      nvec++;
      if (stage_en_o !== 5'b10000) begin
        nerr++; $display("FAIL mem_en k=%0d got %b want 10000", k, stage_en_o);
      end
      nvec++;
      if (stage_flush_o !== 5'b10000) begin
        nerr++; $display("FAIL mem_flush k=%0d got %b want 10000", k, stage_flush_o);
      end
      if (k > 0) begin
        nvec++;
        if (retire_o !== 1'b0) begin
          nerr++; $display("FAIL mem_gap k=%0d got %b want 0", k, retire_o);
        end
      end
      tick();
    end
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (retire_o !== 1'b0) begin
      nerr++; $display("FAIL mem_gap_last got %b want 0", retire_o);
    end
    tick();
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (retire_o !== 1'b1) begin
      nerr++; $display("FAIL mem_resume got %b want 1", retire_o);
    end
    tick();
  endtask

  task automatic test_redirect();
    int fc0;
    fill();
    drive(1'b1, 5'b00010, 1'b0, 1'b1, 1'b0);
    fc0 = fc;
    nvec++;
    if (stage_en_o !== 5'b11111) begin
      nerr++; $display("FAIL redir_en got %b want 11111", stage_en_o);
    end
    nvec++;
    if (stage_flush_o !== 5'b00110) begin
      nerr++; $display("FAIL redir_flush got %b want 00110", stage_flush_o);
    end
    tick();
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (stage_valid_o[2:1] !== 2'b00) begin
      nerr++; $display("FAIL redir_squash got %b want 00", stage_valid_o[2:1]);
    end
    nvec++;
    if (flush_cnt_o !== W'(fc0 + 1)) begin
      nerr++; $display("FAIL redir_cnt got %0d want %0d", flush_cnt_o, (fc0+1)%16);
    end
    tick();
  endtask

  task automatic test_redirect_mem();
    int fc0;
    fill();
    fc0 = fc;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
      nvec++;
      if (stage_flush_o !== 5'b10000 || stage_en_o !== 5'b10000) begin
        nerr++;
        $display("FAIL rmem_hold k=%0d got en %b fl %b want 10000 10000",
                 k, stage_en_o, stage_flush_o);
      end
      tick();
    end
    drive(1'b1, '0, 1'b0, 1'b1, 1'b0);
    nvec++;
    if (flush_cnt_o !== W'(fc0)) begin
      nerr++; $display("FAIL rmem_cnt_held got %0d want %0d", flush_cnt_o, fc0);
    end
    nvec++;
    if (stage_flush_o !== 5'b00110 || stage_en_o !== 5'b11111) begin
      nerr++;
      $display("FAIL rmem_take got en %b fl %b want 11111 00110",
               stage_en_o, stage_flush_o);
    end
    tick();
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (flush_cnt_o !== W'(fc0 + 1)) begin
      nerr++; $display("FAIL rmem_cnt got %0d want %0d", flush_cnt_o, (fc0+1)%16);
    end
    tick();
  endtask

  task automatic test_wrap();
    bit saw;
    logic [W-1:0] prev;
    saw = 1'b0;
    fill();
    drive(1'b1, '0, 1'b0, 1'b0, 1'b1);
    tick();
    prev = 4'hx;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
      nvec++;
      if (retire_cnt_o !== W'(i)) begin
        nerr++; $display("FAIL wrap_cnt i=%0d got %0d want %0d", i, retire_cnt_o, i%16);
      end
      if (prev === 4'd15 && retire_cnt_o === 4'd0) saw = 1'b1;
      prev = retire_cnt_o;
      tick();
    end
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
    nvec++;
    if (retire_cnt_o !== 4'd1 || !saw) begin
      nerr++; $display("FAIL wrap_final got %0d wrapped=%0d want 1 wrapped=1", retire_cnt_o, saw);
    end
  endtask

  task automatic test_async_reset();
    time t0;
    drive(1'b1, '0, 1'b0, 1'b0, 1'b0);
    t0 = $time;
    rstn_i = 1'b0;
    #1;
    nvec++;
    if (stage_valid_o[S-1:1] !== 4'b0000 || retire_o !== 1'b0) begin
      nerr++; $display("FAIL areset_valid got %b want 0000", stage_valid_o[S-1:1]);
    end
    nvec++;
    if ({retire_cnt_o, stall_cnt_o, flush_cnt_o} !== 12'h000) begin
      nerr++;
      $display("FAIL areset_cnt got %h/%h/%h want 0/0/0",
               retire_cnt_o, stall_cnt_o, flush_cnt_o);
    end
    nvec++;
    if ($time - t0 >= 2) begin
      nerr++; $display("FAIL areset_time got %0t want <2", $time - t0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rstn_i = 1'b1;
  endtask

  task automatic test_random();
    bit rd_hold;
    logic [S-1:0] rq;
    rd_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < S; b++) rq[b] = ($urandom_range(0, 9) == 0);
      if (!rd_hold) rd_hold = ($urandom_range(0, 6) == 0);
      drive($urandom_range(0, 3) != 0, rq, $urandom_range(0, 6) == 0,
            rd_hold, $urandom_range(0, 40) == 0);
      nvec++;
      if (stage_valid_o !== ex_valid) begin
        nerr++; $display("FAIL rnd_valid i=%0d got %b want %b", i, stage_valid_o, ex_valid);
      end
      nvec++;
      if (stage_en_o !== ex_en) begin
        nerr++; $display("FAIL rnd_en i=%0d got %b want %b", i, stage_en_o, ex_en);
      end
      nvec++;
      if (stage_flush_o !== ex_flush) begin
        nerr++; $display("FAIL rnd_flush i=%0d got %b want %b", i, stage_flush_o, ex_flush);
      end
      nvec++;
      if (retire_o !== ex_retire) begin
        nerr++; $display("FAIL rnd_retire i=%0d got %b want %b", i, retire_o, ex_retire);
      end
      nvec++;
      if (retire_cnt_o !== W'(rc) || stall_cnt_o !== W'(sc) ||
          flush_cnt_o !== W'(fc)) begin
        nerr++;
        $display("FAIL rnd_cnt i=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                 i, retire_cnt_o, stall_cnt_o, flush_cnt_o, rc, sc, fc);
      end
      if (ex_take) rd_hold = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall_decode();
    test_mem_busy();
    test_redirect();
    test_redirect_mem();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
